ps2_key_controller: RTL and testbench

//  System-clock PS/2 keyboard front end. Synchronises raw ps2_clk/ps2_data, deframes 11-bit

---
 rtl/ps2_pkg.sv | 73 +++++++
 rtl/ps2_key_controller_if.sv | 24 ++
 rtl/ps2_event_fifo.sv | 49 ++++
 rtl/ps2_key_controller.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_controller.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    // Deframer states
    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Mapped scan codes, plain set
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Mapped scan codes, E0-extended set
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit positions in the held-key vector
    localparam int unsigned ACT_UP    = 0;
    localparam int unsigned ACT_LEFT  = 1;
    localparam int unsigned ACT_DOWN  = 2;
    localparam int unsigned ACT_RIGHT = 3;
    localparam int unsigned ACT_SPACE = 4;
    localparam int unsigned ACT_ENTER = 5;
    localparam int unsigned NUM_ACT   = 6;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_evt_t;

    // One-hot mask of the action driven by a code; zero for unmapped codes.
    function automatic logic [NUM_ACT-1:0] act_mask(input logic [7:0] code, input logic ext);
        logic [NUM_ACT-1:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_W:     m[ACT_UP]    = 1'b1;
                SC_A:     m[ACT_LEFT]  = 1'b1;
                SC_S:     m[ACT_DOWN]  = 1'b1;
                SC_D:     m[ACT_RIGHT] = 1'b1;
                SC_SPACE: m[ACT_SPACE] = 1'b1;
                SC_ENTER: m[ACT_ENTER] = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            // Keypad Enter (E0 5A) intentionally falls to default
            case (code)
                SC_UP:    m[ACT_UP]    = 1'b1;
                SC_LEFT:  m[ACT_LEFT]  = 1'b1;
                SC_DOWN:  m[ACT_DOWN]  = 1'b1;
                SC_RIGHT: m[ACT_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_controller_if.sv
// Event stream from the keyboard front end to its consumer (valid/ready).
interface ps2_key_controller_if;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_break,
        output evt_ext,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_break,
        input  evt_ext,
        output evt_ready
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type T = ps2_evt_t
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot a simultaneous push needs when full
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard front end: synchroniser, frame deframer, prefix decode, held-key map
// and event FIFO.
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ps2_clk,
    input  logic                 i_ps2_data,
    output logic [NUM_ACT-1:0]   o_acoes,
    ps2_key_controller_if.master evt_if,
    output logic                 o_frame_err,
    output logic                 o_overflow,
    input  logic                 i_clr_overflow
);
    localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;

    ps2_state_e    r_state;
    ps2_state_e    w_state_d;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    w_bit_cnt_d;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_d;
    logic          r_par;
    logic          w_par_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          w_good_d;
    logic          w_err_d;

    logic          r_good;
    logic [7:0]    r_byte;
    logic          r_frame_err;
    logic          r_ext;
    logic          r_brk;
    logic [NUM_ACT-1:0] r_acoes;
    logic          r_overflow;

    logic          w_emit;
    logic [NUM_ACT-1:0] w_mask;
    ps2_evt_t      w_evt;
    ps2_evt_t      w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev && !w_clk_s;

    // Synchronisers; reset to the idle-high line level so reset creates no fall
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= SYNC_STAGES'({r_clk_sync, i_ps2_clk});
            r_data_sync <= SYNC_STAGES'({r_data_sync, i_ps2_data});
            r_clk_prev  <= w_clk_s;
        end
    end

    // Deframer state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StWaitIdle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_cnt       <= '0;
            r_good      <= 1'b0;
            r_byte      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_shift     <= w_shift_d;
            r_par       <= w_par_d;
            r_cnt       <= w_cnt_d;
            r_good      <= w_good_d;
            r_frame_err <= w_err_d;
            if (w_good_d) r_byte <= r_shift;
        end
    end

    // Deframer next state, idle/timeout counter and frame verdict
    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_par_d     = r_par;
        w_good_d    = 1'b0;
        w_err_d     = 1'b0;
        w_cnt_d     = (r_cnt == TO_LAST) ? r_cnt : r_cnt + CW'(1);
        if (w_fall) w_cnt_d = '0;

        unique case (r_state)
            StWaitIdle: begin
                // Count consecutive high cycles; a low line restarts the count
                if (!w_clk_s) begin
                    w_cnt_d = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_state_d = StIdle;
                end
            end
            StIdle: begin
                if (w_fall && !w_data_s) begin
                    w_state_d   = StData;
                    w_bit_cnt_d = '0;
                end
            end
            StData: begin
                if (w_fall) begin
                    w_shift_d   = {w_data_s, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_d = StParity;
                end else if (r_cnt == TO_LAST) begin
                    w_state_d = StIdle;
                    w_err_d   = 1'b1;
                end
            end
            StParity: begin
                if (w_fall) begin
                    w_par_d   = w_data_s;
                    w_state_d = StStop;
                end else if (r_cnt == TO_LAST) begin
                    w_state_d = StIdle;
                    w_err_d   = 1'b1;
                end
            end
            StStop: begin
                if (w_fall) begin
                    w_state_d = StIdle;
                    if (w_data_s && (^{r_shift, r_par})) w_good_d = 1'b1;
                    else                                  w_err_d  = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_state_d = StIdle;
                    w_err_d   = 1'b1;
                end
            end
            default: w_state_d = StWaitIdle;
        endcase
    end

    assign w_emit = r_good && (r_byte != SC_E0) && (r_byte != SC_F0);
    assign w_mask = act_mask(r_byte, r_ext);
    assign w_evt  = '{code: r_byte, brk: r_brk, ext: r_ext};
    // Full implies non-empty, so only a ready consumer can make room this cycle
    assign w_drop = w_emit && w_full && !evt_if.evt_ready;

    // Prefix flags and held-key vector, updated one cycle after the stop bit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_acoes <= '0;
        end else if (w_err_d) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_good) begin
            if (r_byte == SC_E0) begin
                r_ext <= 1'b1;
            end else if (r_byte == SC_F0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext   <= 1'b0;
                r_brk   <= 1'b0;
                r_acoes <= r_brk ? (r_acoes & ~w_mask) : (r_acoes | w_mask);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear
    always_ff @(posedge i_clk) begin
        if (i_reset)             r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (i_clr_overflow) r_overflow <= 1'b0;
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ps2_evt_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_emit),
        .i_data  (w_evt),
        .o_full  (w_full),
        .i_pop   (evt_if.evt_ready),
        .o_data  (w_head),
        .o_empty (w_empty)
    );

    assign evt_if.evt_valid = !w_empty;
    assign evt_if.evt_code  = w_empty ? 8'h00 : w_head.code;
    assign evt_if.evt_break = !w_empty && w_head.brk;
    assign evt_if.evt_ext   = !w_empty && w_head.ext;

    assign o_acoes     = r_acoes;
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller: directed frame table, hand-written
// latency/timeout/overflow/reset sequences, then randomized frames against a
// byte-level model of the keyboard protocol.
module tb_ps2_key_controller;
    import ps2_pkg::*;

    localparam int unsigned TO    = 200;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       clr_ovf;
    logic [5:0] acoes;
    logic       frame_err;
    logic       overflow;

    ps2_key_controller_if evt_if ();

    ps2_key_controller #(
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_ps2_clk      (ps2_clk),
        .i_ps2_data     (ps2_data),
        .o_acoes        (acoes),
        .evt_if         (evt_if),
        .o_frame_err    (frame_err),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int half = 10;

    // frame_err is a registered one-cycle pulse; count it away from the active edge
    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    // ---------------- reference model (byte level) ----------------
    typedef struct { logic [7:0] code; logic ext; int idx; } map_t;
    map_t       keymap [10];
    ps2_evt_t   m_q [$];
    ps2_evt_t   got_q [$];
    logic       m_ext, m_brk;
    logic [5:0] m_acoes;
    logic       m_ovf;
    int         m_err;

    function automatic int lookup(input logic [7:0] code, input logic ext);
        for (int i = 0; i < 10; i++)
            if (keymap[i].code == code && keymap[i].ext == ext) return keymap[i].idx;
        return -1;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit good);
        int idx;
        if (!good) begin
            m_ext = 1'b0; m_brk = 1'b0; m_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_q.size() < DEPTH) m_q.push_back('{code: b, brk: m_brk, ext: m_ext});
            else m_ovf = 1'b1;
            idx = lookup(b, m_ext);
            if (idx >= 0) m_acoes[idx] = !m_brk;
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_acoes = '0; m_ovf = 1'b0; m_err = err_seen;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(half);
        ps2_clk = 1'b0;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs);
        send_bits(mk_frame(b, bp, bs), 11);
        wait_cyc(5);
    endtask

    // Pop everything the DUT holds and compare it with the model queue
    task automatic drain();
        got_q.delete();
        evt_if.evt_ready = 1'b1;
        for (int g = 0; g < int'(DEPTH) + 4 && evt_if.evt_valid === 1'b1; g++) begin
            got_q.push_back('{code: evt_if.evt_code, brk: evt_if.evt_break,
                              ext: evt_if.evt_ext});
            wait_cyc(1);
        end
        evt_if.evt_ready = 1'b0;
        check("drain_count", 32'(got_q.size()), 32'(m_q.size()));
        for (int i = 0; i < got_q.size() && i < m_q.size(); i++)
            check("drain_event", 32'(got_q[i]), 32'(m_q[i]));
        m_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        logic [5:0] exp_acoes;
        int         exp_err;
    } vec_t;
    vec_t     vt [10];
    ps2_evt_t exp_ev [5];

    task automatic setv(input int i, input logic [7:0] b, input bit bp, input bit bs,
                        input logic [5:0] a, input int e);
        vt[i].b = b; vt[i].bad_par = bp; vt[i].bad_stop = bs;
        vt[i].exp_acoes = a; vt[i].exp_err = e;
    endtask

    initial begin
        int first_valid, first_act, e0, r;
        logic [7:0] b;
        bit bp, bs;

        keymap[0] = '{8'h1D, 1'b0, 0}; keymap[1] = '{8'h1C, 1'b0, 1};
        keymap[2] = '{8'h1B, 1'b0, 2}; keymap[3] = '{8'h23, 1'b0, 3};
        keymap[4] = '{8'h29, 1'b0, 4}; keymap[5] = '{8'h5A, 1'b0, 5};
        keymap[6] = '{8'h75, 1'b1, 0}; keymap[7] = '{8'h6B, 1'b1, 1};
        keymap[8] = '{8'h72, 1'b1, 2}; keymap[9] = '{8'h74, 1'b1, 3};

        setv(0, 8'hF0, 0, 0, 6'b000001, 0);
        setv(1, 8'h1D, 0, 0, 6'b000000, 0);
        setv(2, 8'hE0, 0, 0, 6'b000000, 0);
        setv(3, 8'h75, 0, 0, 6'b000001, 0);
        setv(4, 8'hE0, 0, 0, 6'b000001, 0);
        setv(5, 8'hF0, 0, 0, 6'b000001, 0);
        setv(6, 8'h75, 0, 0, 6'b000000, 0);
        setv(7, 8'h29, 1, 0, 6'b000000, 1);
        setv(8, 8'h29, 0, 1, 6'b000000, 1);
        setv(9, 8'h29, 0, 0, 6'b010000, 0);
        exp_ev[0] = '{code: 8'h1D, brk: 1'b0, ext: 1'b0};
        exp_ev[1] = '{code: 8'h1D, brk: 1'b1, ext: 1'b0};
        exp_ev[2] = '{code: 8'h75, brk: 1'b0, ext: 1'b1};
        exp_ev[3] = '{code: 8'h75, brk: 1'b1, ext: 1'b1};
        exp_ev[4] = '{code: 8'h29, brk: 1'b0, ext: 1'b0};

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; clr_ovf = 1'b0;
        evt_if.evt_ready = 1'b0;
        wait_cyc(3);
        check("rst_acoes", 32'(acoes), 32'(0));
        check("rst_valid", 32'(evt_if.evt_valid), 32'(0));
        check("rst_code", 32'(evt_if.evt_code), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        reset = 1'b0;
        model_reset();
        wait_cyc(TO + 20);

        // Test 1: 1D with exact stop-bit latency (sync 2 + detect + write = 4th edge)
        send_bits(mk_frame(8'h1D, 0, 0), 10);
        ps2_data = 1'b1;
        wait_cyc(half);
        ps2_clk = 1'b0;
        first_valid = 0; first_act = 0;
        for (int k = 1; k <= 8; k++) begin
            wait_cyc(1);
            if (first_valid == 0 && evt_if.evt_valid === 1'b1) first_valid = k;
            if (first_act == 0 && acoes === 6'b000001) first_act = k;
        end
        ps2_clk = 1'b1;
        model_frame(8'h1D, 1'b1);
        check("lat_valid_edge", 32'(first_valid), 32'(4));
        check("lat_acoes_edge", 32'(first_act), 32'(4));
        check("t1_acoes", 32'(acoes), 32'(6'b000001));
        wait_cyc(5);

        // Tests 2-4 via the table
        for (int i = 0; i < 10; i++) begin
            e0 = err_seen;
            send_frame(vt[i].b, vt[i].bad_par, vt[i].bad_stop);
            model_frame(vt[i].b, !(vt[i].bad_par || vt[i].bad_stop));
            check($sformatf("vec%0d_acoes", i), 32'(acoes), 32'(vt[i].exp_acoes));
            check($sformatf("vec%0d_err", i), 32'(err_seen - e0), 32'(vt[i].exp_err));
        end
        drain();
        check("dir_count", 32'(got_q.size()), 32'(5));
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check($sformatf("dir_evt%0d", i), 32'(got_q[i]), 32'(exp_ev[i]));

        // Test 5: F0, then a frame stalled after 5 data bits; flags must clear
        send_frame(8'hF0, 0, 0);
        model_frame(8'hF0, 1'b1);
        e0 = err_seen;
        send_bits(mk_frame(8'h5A, 0, 0), 6);
        wait_cyc(TO + 20);
        model_frame(8'h00, 1'b0);
        check("to_err", 32'(err_seen - e0), 32'(1));
        check("to_no_evt", 32'(evt_if.evt_valid), 32'(0));
        send_frame(8'h5A, 0, 0);
        model_frame(8'h5A, 1'b1);
        check("to_enter", 32'(acoes), 32'(6'b110000));
        drain();

        // Test 6: overflow with consumer stalled
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h10 + 8'(i), 0, 0);
            model_frame(8'h10 + 8'(i), 1'b1);
        end
        check("ovf_set", 32'(overflow), 32'(1));
        check("ovf_acoes", 32'(acoes), 32'(6'b110000));
        clr_ovf = 1'b1; wait_cyc(1); clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'(0));
        m_ovf = 1'b0;
        drain();
        check("ovf_count", 32'(got_q.size()), 32'(DEPTH));
        send_frame(8'h1C, 0, 0);
        send_frame(8'h11, 0, 0);
        send_bits(mk_frame(8'h23, 0, 0), 4);
        reset = 1'b1; wait_cyc(2); reset = 1'b0;
        model_reset();
        check("mid_rst_valid", 32'(evt_if.evt_valid), 32'(0));
        check("mid_rst_acoes", 32'(acoes), 32'(0));
        check("mid_rst_ovf", 32'(overflow), 32'(0));
        // Still waiting for an idle line: a frame right away must be ignored
        e0 = err_seen;
        send_frame(8'h29, 0, 0);
        check("wait_idle_acoes", 32'(acoes), 32'(0));
        check("wait_idle_valid", 32'(evt_if.evt_valid), 32'(0));
        check("wait_idle_err", 32'(err_seen - e0), 32'(0));
        wait_cyc(TO + 20);
        m_err = err_seen;

        // Randomized frames against the model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 15);
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r < 14) b = keymap[$urandom_range(0, 9)].code;
            else             b = 8'($urandom_range(0, 255));
            bp = 1'b0; bs = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1'b1;
                else bs = 1'b1;
            end
            half = $urandom_range(4, 15);
            send_frame(b, bp, bs);
            model_frame(b, !(bp || bs));
            wait_cyc($urandom_range(0, 20));
            check("rnd_acoes", 32'(acoes), 32'(m_acoes));
            check("rnd_err", 32'(err_seen), 32'(m_err));
            if ($urandom_range(0, 7) == 0) begin
                check("rnd_ovf", 32'(overflow), 32'(m_ovf));
                drain();
                clr_ovf = 1'b1; wait_cyc(1); clr_ovf = 1'b0;
                m_ovf = 1'b0;
            end
        end
        check("end_ovf", 32'(overflow), 32'(m_ovf));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
